// File: rtl/sram_arbiter.sv
// Round-robin arbiter and fixed-latency access sequencer between the CPU and
// debug ports and the shared 16-bit asynchronous SRAM pins.
module sram_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Data_to_SRAM,
    output logic              Data_drive,
    input  logic [DATA_W-1:0] Data_from_SRAM,

    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              grant;
    logic              grant_port;
    logic              capture;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              owner_q;
    logic              last_owner;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              in_access;
    logic              in_done;

    // NOTE: every variable written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        grant      = 1'b0;
        grant_port = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    grant      = 1'b1;
                    // On a tie the port that did not win last time goes next.
                    grant_port = (cpu_req && dbg_req) ? ~last_owner : dbg_req;
                    cnt_nxt    = CNT_INIT;
                    state_nxt  = ACCESS;
                end
            end
            ACCESS: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    capture   = ~we_q;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            owner_q     <= 1'b0;
            last_owner  <= 1'b1;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (grant) begin
                addr_q     <= grant_port ? dbg_addr  : cpu_addr;
                we_q       <= grant_port ? dbg_we    : cpu_we;
                wdata_q    <= grant_port ? dbg_wdata : cpu_wdata;
                owner_q    <= grant_port;
                last_owner <= grant_port;
            end
            if (capture && !owner_q) cpu_rdata_q <= Data_from_SRAM;
            if (capture &&  owner_q) dbg_rdata_q <= Data_from_SRAM;
        end
    end

    // Pin-side outputs decode only registered state; requests never reach them directly.
    assign in_access    = (state == ACCESS);
    assign in_done      = (state == DONE);

    assign Mem_CE       = ~in_access;
    assign Mem_UB       = ~in_access;
    assign Mem_LB       = ~in_access;
    assign Mem_OE       = ~(in_access & ~we_q);
    assign Mem_WE       = ~(in_access &  we_q);
    assign ADDR         = addr_q;
    assign Data_to_SRAM = wdata_q;
    // Write data stays on the bus through DONE as hold time.
    assign Data_drive   = we_q & (in_access | in_done);

    assign cpu_ack      = in_done & ~owner_q;
    assign dbg_ack      = in_done &  owner_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign dbg_rdata    = dbg_rdata_q;
    assign busy         = (state != IDLE);
    assign owner        = owner_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-timeline model and a behavioural SRAM.
`timescale 1ns/1ps
module tb_sram_arbiter;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int W  = 2;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_pass  = 0;

    // Main instance, WAIT_CYCLES = 2
    logic          cpu_req, cpu_we, cpu_ack, dbg_req, dbg_we, dbg_ack;
    logic [AW-1:0] cpu_addr, dbg_addr, ADDR;
    logic [DW-1:0] cpu_wdata, cpu_rdata, dbg_wdata, dbg_rdata;
    logic          Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Data_drive, busy, owner;
    logic [DW-1:0] Data_to_SRAM;
    logic [DW-1:0] Data_from_SRAM = '0;
    logic [4:0]    strb;
    assign strb = {Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_drive(Data_drive),
        .Data_from_SRAM(Data_from_SRAM), .busy(busy), .owner(owner)
    );

    // Second instance, WAIT_CYCLES = 1, backed by a ROM-like read bus
    logic          b_cpu_req, b_cpu_we, b_cpu_ack, b_dbg_req, b_dbg_we, b_dbg_ack;
    logic [AW-1:0] b_cpu_addr, b_dbg_addr, b_ADDR;
    logic [DW-1:0] b_cpu_wdata, b_cpu_rdata, b_dbg_wdata, b_dbg_rdata, b_Data_to_SRAM, b_Data_from_SRAM;
    logic          b_Mem_CE, b_Mem_UB, b_Mem_LB, b_Mem_OE, b_Mem_WE, b_Data_drive, b_busy, b_owner;
    logic [4:0]    b_strb;
    assign b_strb = {b_Mem_CE, b_Mem_UB, b_Mem_LB, b_Mem_OE, b_Mem_WE};
    assign b_Data_from_SRAM = b_ADDR[15:0] ^ 16'hA5A5;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) u_dut_w1 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .dbg_req(b_dbg_req), .dbg_we(b_dbg_we), .dbg_addr(b_dbg_addr), .dbg_wdata(b_dbg_wdata),
        .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
        .Mem_CE(b_Mem_CE), .Mem_UB(b_Mem_UB), .Mem_LB(b_Mem_LB), .Mem_OE(b_Mem_OE), .Mem_WE(b_Mem_WE),
        .ADDR(b_ADDR), .Data_to_SRAM(b_Data_to_SRAM), .Data_drive(b_Data_drive),
        .Data_from_SRAM(b_Data_from_SRAM), .busy(b_busy), .owner(b_owner)
    );

    // Behavioural asynchronous SRAM; unwritten cells read a fixed address pattern.
    logic [DW-1:0] sram_mem [bit [AW-1:0]];
    always @(posedge Clk)
        if (Mem_CE === 1'b0 && Mem_WE === 1'b0) sram_mem[ADDR] = Data_to_SRAM;
    always @(negedge Clk)
        Data_from_SRAM <= sram_mem.exists(ADDR) ? sram_mem[ADDR] : (ADDR[15:0] ^ 16'h5A5A);

    logic [DW-1:0] exp_rd [2];

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
        b_dbg_req = 1'b0; b_dbg_we = 1'b0; b_dbg_addr = '0; b_dbg_wdata = '0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        cpu_req = 1'b1; dbg_req = 1'b1;
        repeat (3) @(negedge Clk);
        n_total++; if (strb !== 5'b11111) $display("FAIL reset strobes: got %b want 11111", strb); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset busy: got %b want 0", busy); else n_pass++;
        n_total++; if (owner !== 1'b0) $display("FAIL reset owner: got %b want 0", owner); else n_pass++;
        n_total++; if (ADDR !== '0) $display("FAIL reset ADDR: got %h want 0", ADDR); else n_pass++;
        n_total++; if (Data_to_SRAM !== '0 || Data_drive !== 1'b0)
            $display("FAIL reset data: got %h/%b want 0000/0", Data_to_SRAM, Data_drive); else n_pass++;
        n_total++; if ({dbg_ack, cpu_ack} !== 2'b00) $display("FAIL reset acks: got %b want 00", {dbg_ack, cpu_ack}); else n_pass++;
        n_total++; if (cpu_rdata !== '0 || dbg_rdata !== '0)
            $display("FAIL reset rdata: got %h/%h want 0000/0000", cpu_rdata, dbg_rdata); else n_pass++;
        n_total++; if (b_strb !== 5'b11111 || b_busy !== 1'b0)
            $display("FAIL reset w1 strobes/busy: got %b/%b want 11111/0", b_strb, b_busy); else n_pass++;
        idle_inputs();
        Reset = 1'b0;
        @(negedge Clk);
        n_total++; if (busy !== 1'b0) $display("FAIL reset idle busy: got %b want 0", busy); else n_pass++;
        exp_rd[0] = '0; exp_rd[1] = '0;
    endtask

    // One isolated access on the main instance, checked cycle by cycle from T to T+W+2.
    task automatic single_access(input string tag, input bit port, input bit we,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                                 input logic [DW-1:0] rd_exp, input bit drop_early);
        logic [4:0] s_acc;
        s_acc = we ? 5'b00010 : 5'b00001;
        @(negedge Clk);
        if (!port) begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
        else       begin dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wd; end
        for (int k = 1; k <= W; k++) begin
            @(negedge Clk);
            n_total++; if (strb !== s_acc) $display("FAIL %s strobes T+%0d: got %b want %b", tag, k, strb, s_acc); else n_pass++;
            n_total++; if (ADDR !== addr) $display("FAIL %s ADDR T+%0d: got %h want %h", tag, k, ADDR, addr); else n_pass++;
            n_total++; if (busy !== 1'b1 || owner !== port)
                $display("FAIL %s busy/owner T+%0d: got %b/%b want 1/%b", tag, k, busy, owner, port); else n_pass++;
            n_total++; if (Data_drive !== we) $display("FAIL %s drive T+%0d: got %b want %b", tag, k, Data_drive, we); else n_pass++;
            if (we) begin
                n_total++; if (Data_to_SRAM !== wd) $display("FAIL %s wdata T+%0d: got %h want %h", tag, k, Data_to_SRAM, wd); else n_pass++;
            end
            n_total++; if ({dbg_ack, cpu_ack} !== 2'b00) $display("FAIL %s early ack T+%0d: got %b want 00", tag, k, {dbg_ack, cpu_ack}); else n_pass++;
            // Request fields only matter in the grant cycle
            if (!port) begin
                cpu_addr = 20'($urandom); cpu_wdata = 16'($urandom); cpu_we = 1'($urandom);
                if (drop_early) cpu_req = 1'b0;
            end else begin
                dbg_addr = 20'($urandom); dbg_wdata = 16'($urandom); dbg_we = 1'($urandom);
                if (drop_early) dbg_req = 1'b0;
            end
        end
        @(negedge Clk);
        if (!we) exp_rd[port] = rd_exp;
        n_total++; if ({dbg_ack, cpu_ack} !== (port ? 2'b10 : 2'b01))
            $display("FAIL %s ack: got %b want %b", tag, {dbg_ack, cpu_ack}, port ? 2'b10 : 2'b01); else n_pass++;
        n_total++; if (strb !== 5'b11111) $display("FAIL %s done strobes: got %b want 11111", tag, strb); else n_pass++;
        n_total++; if (Data_drive !== we) $display("FAIL %s hold drive: got %b want %b", tag, Data_drive, we); else n_pass++;
        if (we) begin
            n_total++; if (Data_to_SRAM !== wd) $display("FAIL %s hold wdata: got %h want %h", tag, Data_to_SRAM, wd); else n_pass++;
        end
        n_total++; if (cpu_rdata !== exp_rd[0]) $display("FAIL %s cpu_rdata: got %h want %h", tag, cpu_rdata, exp_rd[0]); else n_pass++;
        n_total++; if (dbg_rdata !== exp_rd[1]) $display("FAIL %s dbg_rdata: got %h want %h", tag, dbg_rdata, exp_rd[1]); else n_pass++;
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge Clk);
        n_total++; if (busy !== 1'b0 || {dbg_ack, cpu_ack} !== 2'b00 || Data_drive !== 1'b0)
            $display("FAIL %s after: got busy=%b ack=%b drive=%b want 0/00/0", tag, busy, {dbg_ack, cpu_ack}, Data_drive); else n_pass++;
        if (drop_early) begin
            @(negedge Clk);
            n_total++; if (busy !== 1'b0) $display("FAIL %s second access: got busy=%b want 0", tag, busy); else n_pass++;
        end
    endtask

    task automatic test_cpu_read();
        sram_mem[20'h00010] = 16'h1234;
        single_access("cpu_read", 1'b0, 1'b0, 20'h00010, 16'h0000, 16'h1234, 1'b0);
    endtask

    task automatic test_dbg_write_readback();
        single_access("dbg_write", 1'b1, 1'b1, 20'h0ABCD, 16'hBEEF, 16'h0000, 1'b0);
        single_access("cpu_readback", 1'b0, 1'b0, 20'h0ABCD, 16'h0000, 16'hBEEF, 1'b0);
    endtask

    task automatic test_contention();
        bit e_own;
        bit e_busy;
        logic [1:0] e_ack;
        @(negedge Clk);
        Reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 20'h0ABCD;
        @(negedge Clk);
        Reset = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge Clk);
            e_own  = (k == 0) ? 1'b0 : ((((k - 1) / 4) % 2) == 1);
            e_busy = (k % 4) != 0;
            e_ack  = ((k % 4) != 3) ? 2'b00 : ((((k / 4) % 2) == 1) ? 2'b10 : 2'b01);
            if (e_ack == 2'b01) exp_rd[0] = 16'h1234;
            if (e_ack == 2'b10) exp_rd[1] = 16'hBEEF;
            n_total++; if ({dbg_ack, cpu_ack} !== e_ack) $display("FAIL contention ack c%0d: got %b want %b", k, {dbg_ack, cpu_ack}, e_ack); else n_pass++;
            n_total++; if (owner !== e_own || busy !== e_busy)
                $display("FAIL contention owner/busy c%0d: got %b/%b want %b/%b", k, owner, busy, e_own, e_busy); else n_pass++;
            n_total++; if (cpu_rdata !== exp_rd[0] || dbg_rdata !== exp_rd[1])
                $display("FAIL contention rdata c%0d: got %h/%h want %h/%h", k, cpu_rdata, dbg_rdata, exp_rd[0], exp_rd[1]); else n_pass++;
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge Clk);
        n_total++; if (busy !== 1'b0) $display("FAIL contention release busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_midaccess_reset();
        @(negedge Clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00010;
        @(negedge Clk);
        @(negedge Clk);
        n_total++; if (strb !== 5'b00001) $display("FAIL midreset access strobes: got %b want 00001", strb); else n_pass++;
        Reset = 1'b1;
        @(negedge Clk);
        exp_rd[0] = '0; exp_rd[1] = '0;
        n_total++; if (strb !== 5'b11111 || busy !== 1'b0)
            $display("FAIL midreset strobes/busy: got %b/%b want 11111/0", strb, busy); else n_pass++;
        n_total++; if (cpu_ack !== 1'b0 || cpu_rdata !== '0)
            $display("FAIL midreset ack/rdata: got %b/%h want 0/0000", cpu_ack, cpu_rdata); else n_pass++;
        n_total++; if (ADDR !== '0 || Data_drive !== 1'b0 || owner !== 1'b0 || dbg_rdata !== '0)
            $display("FAIL midreset regs: got ADDR=%h drive=%b owner=%b dbg=%h want 0", ADDR, Data_drive, owner, dbg_rdata); else n_pass++;
        Reset = 1'b0; cpu_req = 1'b0;
        @(negedge Clk);
        n_total++; if (cpu_ack !== 1'b0 || busy !== 1'b0)
            $display("FAIL midreset late ack: got ack=%b busy=%b want 0/0", cpu_ack, busy); else n_pass++;
        single_access("post_reset_read", 1'b0, 1'b0, 20'h00010, 16'h0000, 16'h1234, 1'b0);
    endtask

    task automatic test_early_drop();
        single_access("early_drop", 1'b0, 1'b0, 20'h00010, 16'h0000, 16'h1234, 1'b1);
    endtask

    task automatic test_wait1();
        logic [AW-1:0] a;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            a = 20'($urandom);
            b_cpu_req = 1'b1; b_cpu_we = 1'b0; b_cpu_addr = a;
            @(negedge Clk);
            n_total++; if (b_strb !== 5'b00001 || b_ADDR !== a)
                $display("FAIL w1 access: got %b/%h want 00001/%h", b_strb, b_ADDR, a); else n_pass++;
            n_total++; if (b_cpu_ack !== 1'b0 || b_busy !== 1'b1)
                $display("FAIL w1 T+1 ack/busy: got %b/%b want 0/1", b_cpu_ack, b_busy); else n_pass++;
            b_cpu_addr = ~a;
            @(negedge Clk);
            n_total++; if (b_cpu_ack !== 1'b1 || b_strb !== 5'b11111)
                $display("FAIL w1 T+2 ack/strobes: got %b/%b want 1/11111", b_cpu_ack, b_strb); else n_pass++;
            n_total++; if (b_cpu_rdata !== (a[15:0] ^ 16'hA5A5))
                $display("FAIL w1 rdata: got %h want %h", b_cpu_rdata, a[15:0] ^ 16'hA5A5); else n_pass++;
            b_cpu_req = 1'b0;
            @(negedge Clk);
            n_total++; if (b_cpu_ack !== 1'b0 || b_busy !== 1'b0 || b_dbg_rdata !== '0)
                $display("FAIL w1 after: got ack=%b busy=%b dbg=%h want 0/0/0000", b_cpu_ack, b_busy, b_dbg_rdata); else n_pass++;
        end
    endtask

    // Randomized two-port traffic against a timeline model: a grant at cycle T
    // gives ACCESS for T+1..T+W, DONE/ack at T+W+1, next arbitration at T+W+2.
    task automatic test_random();
        logic [DW-1:0] ref_mem [bit [AW-1:0]];
        int            remaining [2];
        bit            has_op [2];
        bit            granted [2];
        int            gap [2];
        bit            op_we [2];
        logic [AW-1:0] op_addr [2];
        logic [DW-1:0] op_wd [2];
        bit            m_active, m_port, m_we, m_owner, m_last;
        int            m_t, d, n;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wd;
        bit            acc_c, done_c, idle_c, e_drive;
        logic [4:0]    e_strb;
        logic [1:0]    e_ack;

        @(negedge Clk);
        Reset = 1'b1; idle_inputs();
        @(negedge Clk);
        Reset = 1'b0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        m_active = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_port = 1'b0; m_we = 1'b0; m_t = 0;
        m_addr = '0; m_wd = '0;
        for (int p = 0; p < 2; p++) begin
            remaining[p] = 25; has_op[p] = 1'b0; granted[p] = 1'b0; gap[p] = 0;
        end
        n = 0;
        while ((remaining[0] + remaining[1] > 0 || has_op[0] || has_op[1] || m_active) && n < 3000) begin
            acc_c = 1'b0; done_c = 1'b0;
            if (m_active) begin
                d = n - m_t;
                acc_c  = (d >= 1 && d <= W);
                done_c = (d == W + 1);
            end
            idle_c = !acc_c && !done_c;
            if (done_c) begin
                if (m_we) ref_mem[m_addr] = m_wd;
                else exp_rd[m_port] = ref_mem.exists(m_addr) ? ref_mem[m_addr] : (m_addr[15:0] ^ 16'h5A5A);
            end
            e_strb  = acc_c ? (m_we ? 5'b00010 : 5'b00001) : 5'b11111;
            e_ack   = done_c ? (m_port ? 2'b10 : 2'b01) : 2'b00;
            e_drive = !idle_c && m_we;

            n_total++; if (strb !== e_strb) $display("FAIL rand strobes c%0d: got %b want %b", n, strb, e_strb); else n_pass++;
            n_total++; if ({dbg_ack, cpu_ack} !== e_ack) $display("FAIL rand ack c%0d: got %b want %b", n, {dbg_ack, cpu_ack}, e_ack); else n_pass++;
            n_total++; if (busy !== !idle_c || owner !== m_owner)
                $display("FAIL rand busy/owner c%0d: got %b/%b want %b/%b", n, busy, owner, !idle_c, m_owner); else n_pass++;
            n_total++; if (Data_drive !== e_drive) $display("FAIL rand drive c%0d: got %b want %b", n, Data_drive, e_drive); else n_pass++;
            if (!idle_c) begin
                n_total++; if (ADDR !== m_addr) $display("FAIL rand ADDR c%0d: got %h want %h", n, ADDR, m_addr); else n_pass++;
            end
            if (e_drive) begin
                n_total++; if (Data_to_SRAM !== m_wd) $display("FAIL rand wdata c%0d: got %h want %h", n, Data_to_SRAM, m_wd); else n_pass++;
            end
            n_total++; if (cpu_rdata !== exp_rd[0] || dbg_rdata !== exp_rd[1])
                $display("FAIL rand rdata c%0d: got %h/%h want %h/%h", n, cpu_rdata, dbg_rdata, exp_rd[0], exp_rd[1]); else n_pass++;

            if (done_c) begin
                m_active = 1'b0; has_op[m_port] = 1'b0; granted[m_port] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                if (!has_op[p] && remaining[p] > 0) begin
                    if (gap[p] > 0) gap[p]--;
                    else begin
                        has_op[p]  = 1'b1;
                        remaining[p]--;
                        op_we[p]   = 1'($urandom);
                        op_addr[p] = 20'h80000 | 20'($urandom_range(0, 7));
                        op_wd[p]   = 16'($urandom);
                        gap[p]     = $urandom_range(0, 2);
                    end
                end
            end
            cpu_req = has_op[0];
            if (has_op[0] && !granted[0]) begin cpu_we = op_we[0]; cpu_addr = op_addr[0]; cpu_wdata = op_wd[0]; end
            else begin cpu_we = 1'($urandom); cpu_addr = 20'($urandom); cpu_wdata = 16'($urandom); end
            dbg_req = has_op[1];
            if (has_op[1] && !granted[1]) begin dbg_we = op_we[1]; dbg_addr = op_addr[1]; dbg_wdata = op_wd[1]; end
            else begin dbg_we = 1'($urandom); dbg_addr = 20'($urandom); dbg_wdata = 16'($urandom); end

            if (idle_c && (has_op[0] || has_op[1])) begin
                m_port   = (has_op[0] && has_op[1]) ? !m_last : has_op[1];
                m_active = 1'b1;
                m_t      = n;
                m_we     = op_we[m_port];
                m_addr   = op_addr[m_port];
                m_wd     = op_wd[m_port];
                granted[m_port] = 1'b1;
                m_owner  = m_port;
                m_last   = m_port;
            end
            n++;
            @(negedge Clk);
        end
        n_total++; if (n >= 3000) $display("FAIL rand timeout: got %0d cycles want < 3000", n); else n_pass++;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        Reset = 1'b1;
        test_reset();
        test_cpu_read();
        test_dbg_write_readback();
        test_contention();
        test_midaccess_reset();
        test_early_drop();
        test_wait1();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

endmodule
